// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: forwarding select codes and the in-flight
// destination descriptor used by the EX/MEM hazard tracking.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_dst_t;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  function automatic logic dst_match(input stage_dst_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == r);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding-select priority encoder for one source register: the newer EX
// producer wins over the older MEM producer; otherwise use the register file.
module fwd_sel_calc
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  stage_dst_t               ex,
  input  stage_dst_t               mem,
  input  logic [REG_AW-1:0]        src,
  output logic [SEL_W-1:0]         sel
);

  always_comb begin
    sel = FWD_RF;
    if (dst_match(ex, src)) begin
      sel = FWD_MEM;
    end else if (dst_match(mem, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and load-use hazard control: tracks EX/MEM destinations,
// registers operand mux selects, raises stall/bubble. Optional FWD_PERF_CNT_EN
// adds a saturating stall counter.
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic              ex_bubble,
  output logic [SEL_W-1:0]  fwd_a_sel,
`ifdef FWD_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_count,
`endif
  output logic [SEL_W-1:0]  fwd_b_sel
);

  stage_dst_t       ex_q;
  stage_dst_t       mem_q;
  stage_dst_t       id_dst;
  logic [SEL_W-1:0] sel_a_next;
  logic [SEL_W-1:0] sel_b_next;
  logic             load_hit;

  always_comb begin
    id_dst          = '0;
    id_dst.valid    = id_valid;
    id_dst.rd       = id_rd;
    id_dst.regwrite = id_regwrite;
    id_dst.memread  = id_memread;
  end

  fwd_sel_calc #(.SEL_W(SEL_W)) u_sel_a (
    .ex  (ex_q),
    .mem (mem_q),
    .src (id_rs1),
    .sel (sel_a_next)
  );

  fwd_sel_calc #(.SEL_W(SEL_W)) u_sel_b (
    .ex  (ex_q),
    .mem (mem_q),
    .src (id_rs2),
    .sel (sel_b_next)
  );

  // A load in EX cannot forward yet; hold ID one cycle so it resolves from MEM.
  always_comb begin
    load_hit  = ex_q.memread && (dst_match(ex_q, id_rs1) || dst_match(ex_q, id_rs2));
    stall     = id_valid && !flush && load_hit;
    ex_bubble = stall || flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      mem_q <= ex_q;
      if (ex_bubble) begin
        ex_q      <= '0;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else begin
        ex_q      <= id_dst;
        fwd_a_sel <= sel_a_next;
        fwd_b_sel <= sel_b_next;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding distances, load-use stall,
// x0, flush priority and mid-stream reset; stall_count checked with FWD_PERF_CNT_EN.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic       stall;
  logic       ex_bubble;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] stall_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .SEL_W(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .ex_bubble   (ex_bubble),
    .fwd_a_sel   (fwd_a_sel),
`ifdef FWD_PERF_CNT_EN
    .stall_count (stall_count),
`endif
    .fwd_b_sel   (fwd_b_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid    = v;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef FWD_PERF_CNT_EN
    chk(tag, {16'h0, stall_count}, {16'h0, exp});
`else
    if (exp == 16'hffff) $display("unused %s", tag);
`endif
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    id_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bubble", {31'h0, ex_bubble}, 32'h0);
    chk("rst_sel_a", {30'h0, fwd_a_sel}, 32'h0);
    chk("rst_sel_b", {30'h0, fwd_b_sel}, 32'h0);
    chk_cnt("rst_cnt", 16'd0);

    // back-to-back: add x5 then sub reading x5
    id_in(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    id_in(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
    chk("b2b_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("b2b_sel_a", {30'h0, fwd_a_sel}, 32'h2);
    chk("b2b_sel_b", {30'h0, fwd_b_sel}, 32'h0);

    // distance 2: x7 in MEM
    id_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    id_in(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
    tick();
    id_in(1'b1, 5'd0, 5'd7, 5'd10, 1'b1, 1'b0);
    chk("d2_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("d2_sel_b", {30'h0, fwd_b_sel}, 32'h1);
    chk("d2_sel_a", {30'h0, fwd_a_sel}, 32'h0);

    // x7 in both EX and MEM: newer wins
    id_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    id_in(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    id_in(1'b1, 5'd0, 5'd7, 5'd11, 1'b1, 1'b0);
    tick();
    chk("prio_sel_b", {30'h0, fwd_b_sel}, 32'h2);

    // load-use: lw x3 then add reading x3
    id_in(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
    tick();
    id_in(1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0);
    chk("lu_stall", {31'h0, stall}, 32'h1);
    chk("lu_bubble", {31'h0, ex_bubble}, 32'h1);
    tick();
    chk("lu_bub_sel_a", {30'h0, fwd_a_sel}, 32'h0);
    chk("lu_stall2", {31'h0, stall}, 32'h0);
    chk("lu_bubble2", {31'h0, ex_bubble}, 32'h0);
    tick();
    chk("lu_sel_a", {30'h0, fwd_a_sel}, 32'h1);
    chk("lu_sel_b", {30'h0, fwd_b_sel}, 32'h0);
    chk_cnt("lu_cnt", 16'd1);

    // x0 load producer never matches
    id_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    id_in(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    chk("x0_stall", {31'h0, stall}, 32'h0);
    tick();
    chk("x0_sel_a", {30'h0, fwd_a_sel}, 32'h0);
    chk("x0_sel_b", {30'h0, fwd_b_sel}, 32'h0);

    // invalid ID slot never stalls on a load hit
    id_in(1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1);
    tick();
    id_in(1'b0, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("inv_stall", {31'h0, stall}, 32'h0);
    tick();

    // flush during load-use
    id_in(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    id_in(1'b1, 5'd4, 5'd0, 5'd14, 1'b1, 1'b0);
    chk("fl_stall", {31'h0, stall}, 32'h0);
    chk("fl_bubble", {31'h0, ex_bubble}, 32'h1);
    tick();
    flush = 1'b0;
    chk("fl_sel_a", {30'h0, fwd_a_sel}, 32'h0);
    id_in(1'b1, 5'd14, 5'd4, 5'd15, 1'b1, 1'b0);
    chk("fl_ex_inv", {31'h0, stall}, 32'h0);
    tick();
    chk("fl_next_a", {30'h0, fwd_a_sel}, 32'h0);
    chk("fl_next_b", {30'h0, fwd_b_sel}, 32'h1);
    chk_cnt("fl_cnt", 16'd1);

    // reset mid-stall
    id_in(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0);
    tick();
    id_in(1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 1'b1);
    tick();
    id_in(1'b1, 5'd16, 5'd15, 5'd17, 1'b1, 1'b0);
    chk("rm_stall_pre", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm_stall", {31'h0, stall}, 32'h0);
    chk("rm_sel_a", {30'h0, fwd_a_sel}, 32'h0);
    chk("rm_sel_b", {30'h0, fwd_b_sel}, 32'h0);
    chk_cnt("rm_cnt", 16'd0);
    tick();
    chk("rm_next_a", {30'h0, fwd_a_sel}, 32'h0);
    chk("rm_next_b", {30'h0, fwd_b_sel}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
